// File: rtl/telem_ft_pkg.sv
// Shared constants, FSM state type and frame word selection for telem_ft_packer.
package telem_ft_pkg;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;
    localparam int          WORDS_PER_FRAME   = 7;
    localparam int          PKT_W             = 88;
    localparam int          SEQ_W             = 8;
    localparam int          FRAME_W           = PKT_W + SEQ_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Word idx of a frame whose register holds {seq, payload}; idx 0 is the sync word.
    function automatic logic [15:0] frame_word(input logic [FRAME_W-1:0] frame,
                                               input logic [2:0]         idx,
                                               input logic [15:0]        sync);
        logic [15:0] w;
        w = sync;
        case (idx)
            3'd1:    w = frame[95:80];
            3'd2:    w = frame[79:64];
            3'd3:    w = frame[63:48];
            3'd4:    w = frame[47:32];
            3'd5:    w = frame[31:16];
            3'd6:    w = frame[15:0];
            default: w = sync;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/telem_ft_packer_pkt_fifo.sv
// Generic show-ahead synchronous FIFO; push ignored when full, pop ignored when empty.
module pkt_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/telem_ft_packer.sv
// Buffers telemetry packets, tags them with a sequence number and streams
// them as 7-word framed 16-bit words into the ft TX port under backpressure.
module telem_ft_packer #(
    parameter int          PKT_W     = telem_ft_pkg::PKT_W,
    parameter int          PKT_DEPTH = 4,
    parameter logic [15:0] SYNC_WORD = telem_ft_pkg::SYNC_WORD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PKT_W-1:0] packet_data,
    input  logic             packet_valid,
    input  logic             enable,
    output logic [15:0]      ui_din,
    output logic [1:0]       ui_din_be,
    output logic             ui_din_valid,
    input  logic             ui_din_full,
    output logic [31:0]      drop_count,
    output logic [31:0]      sent_count,
    output logic             busy
);
    import telem_ft_pkg::*;

    localparam logic [2:0] LAST_IDX = 3'(WORDS_PER_FRAME - 1);

    state_t             state, state_n;
    logic [2:0]         idx, idx_n;
    logic [FRAME_W-1:0] frame, frame_n;
    logic [15:0]        din_n;
    logic               valid_n;
    logic [SEQ_W-1:0]   seq;

    logic               accept;
    logic               xfer;
    logic               frame_done;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FRAME_W-1:0] fifo_dout;

    assign accept    = packet_valid && enable;
    assign fifo_push = accept && !fifo_full;
    assign xfer      = ui_din_valid && !ui_din_full;
    assign ui_din_be = 2'b11;
    assign busy      = !fifo_empty || (state == SEND);

    pkt_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (PKT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   ({seq, packet_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and next-word logic; the final word's transfer reloads the
    // frame register directly so back-to-back frames have no bubble.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        frame_n    = frame;
        din_n      = ui_din;
        valid_n    = ui_din_valid;
        fifo_pop   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    frame_n  = fifo_dout;
                    idx_n    = '0;
                    din_n    = SYNC_WORD;
                    valid_n  = 1'b1;
                    state_n  = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx == LAST_IDX) begin
                        frame_done = 1'b1;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            frame_n  = fifo_dout;
                            idx_n    = '0;
                            din_n    = SYNC_WORD;
                        end else begin
                            valid_n = 1'b0;
                            state_n = IDLE;
                        end
                    end else begin
                        idx_n = idx + 3'd1;
                        din_n = frame_word(frame, idx + 3'd1, SYNC_WORD);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM, frame register and registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            frame        <= '0;
            ui_din       <= '0;
            ui_din_valid <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            frame        <= frame_n;
            ui_din       <= din_n;
            ui_din_valid <= valid_n;
        end
    end

    // Sequence tag and diagnostic counters; drops saturate, sends wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq        <= '0;
            drop_count <= '0;
            sent_count <= '0;
        end else begin
            if (fifo_push) seq <= seq + 1'b1;
            if (accept && fifo_full && (drop_count != '1)) drop_count <= drop_count + 32'd1;
            if (frame_done) sent_count <= sent_count + 32'd1;
        end
    end

endmodule
